detection_trip_filter: RTL and testbench
========================================

Name: detection_trip_filter

Overview:
- Downstream consumer of the decision-tree fault classifier's per-sample class output.
- Converts noisy per-sample classifications into a debounced, latched protection trip.
- Trips only after TRIP_CNT consecutive valid fault samples.
- Once tripped, holds the trip until operator acknowledge, then CLEAR_CNT consecutive healthy samples.
- Sits between the classifier and the breaker/alarm interface.

Parameters:
- C, 1: width of the class input; matches the classifier output width.
- FAULT_CLASS, 'd0: class code that counts as a fault; every other code counts as healthy.
- TRIP_CNT, 4: consecutive valid fault samples needed to trip; legal range 1..255.
- CLEAR_CNT, 8: consecutive valid healthy samples needed to release after acknowledge; legal range 1..255.
- EW, 16: width of the saturating fault-event counter.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- cls_in, input, C: class from the classifier; sampled only when cls_valid=1.
- cls_valid, input, 1: cls_in carries a new sample this cycle.
- ack_clear, input, 1: operator acknowledge; level-sampled each cycle.
- trip, output, 1: latched trip; registered.
- trip_pulse, output, 1: one-cycle strobe on each NORMAL/ARMING -> TRIPPED entry.
- pending, output, 1: high while ARMING, i.e. fault run in progress but below threshold.
- fault_events, output, EW: count of trips since reset; saturates at all-ones.
- state_o, output, 2: current state encoding, for debug.

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high on rst, dominates every other input, and can be applied mid-operation including while tripped.
- Reset values: state=NORMAL, run counter=0, trip=0, trip_pulse=0, pending=0, fault_events=0, state_o=2'd0.
- A fault sample is cls_valid=1 with cls_in==FAULT_CLASS. A healthy sample is cls_valid=1 with any other value.
- With cls_valid=0, the counters and state hold. ack_clear is the only exception.
- All outputs are registered. Latency from the accepting edge of the deciding sample to the output change is 1 cycle.
- Run counter is 8 bits, saturating, cleared on every state change.
- States:
  - NORMAL (0):
    - Fault sample: if TRIP_CNT==1 -> TRIPPED; else cnt=1 -> ARMING.
    - Healthy sample: stay.
  - ARMING (1):
    - Fault sample: cnt+1. When cnt+1==TRIP_CNT -> TRIPPED.
    - Healthy sample: -> NORMAL, cnt=0.
  - TRIPPED (2):
    - ack_clear=1 -> RECOVER, cnt=0.
    - Samples are ignored, including a sample in the same cycle as ack_clear.
  - RECOVER (3):
    - Healthy sample: cnt+1. When cnt+1==CLEAR_CNT -> NORMAL.
    - Fault sample: -> TRIPPED, cnt=0, with no trip_pulse and no event increment.
    - ack_clear is ignored.
- On every NORMAL/ARMING -> TRIPPED entry: trip_pulse=1 for exactly one cycle, and fault_events increments unless it is all-ones.
- trip=1 exactly when state is TRIPPED or RECOVER. pending=1 exactly when state is ARMING.
- ack_clear held high is harmless. It only matters in TRIPPED, and it does not re-arm a new trip.
- cls_in values outside 0..2^C-1 cannot occur. No X-propagation handling is required.

Decomposition:
- Shared package detection_pkg:
  - typedef enum logic [1:0] trip_state_e {NORMAL, ARMING, TRIPPED, RECOVER}.
  - Localparams for the default FAULT_CLASS, TRIP_CNT and CLEAR_CNT.
- Sub-module run_counter: 8-bit saturating counter with clr, inc and a terminal-match output against a count input. It is instantiated once and shared by the ARMING and RECOVER phases.
- Top level holds the FSM, the event counter and the output registers.

Test Plan:
1. Reset, then fault samples at cycles 1,2,3,4 (TRIP_CNT=4): pending=1 from cycle 2, trip=1 and trip_pulse=1 at cycle 5 only, fault_events=1.
2. Fault samples F,F,F then healthy, then F,F,F,F: no trip after the first run, pending falls after the healthy sample, trip asserts after the 4th fault of the second run, fault_events=1.
3. Faults interleaved with cls_valid=0 gaps (F,-,F,-,-,F,F): gaps are not counted and do not break the run; trips after the 4th valid fault.
4. Tripped, hold ack_clear=0 while sending 20 healthy samples: trip stays 1. Then ack_clear=1 for one cycle with a healthy sample in the same cycle, followed by 8 healthy samples: that same-cycle sample is not counted, and trip falls 1 cycle after the 8th.
5. In RECOVER after 5 healthy samples, send 1 fault: state returns to TRIPPED, trip stays 1, trip_pulse=0, fault_events unchanged.
6. Assert rst while in RECOVER and again while ARMING: all outputs return to 0 on the next edge. With EW=2, four trips leave fault_events=3 (saturated).

Source files
------------

// File: rtl/detection_pkg.sv
// Shared types and default settings for the detection trip filter.
package detection_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    ARMING  = 2'd1,
    TRIPPED = 2'd2,
    RECOVER = 2'd3
  } trip_state_e;

  localparam int unsigned DEF_FAULT_CLASS = 0;
  localparam int unsigned DEF_TRIP_CNT    = 4;
  localparam int unsigned DEF_CLEAR_CNT   = 8;

endpackage

// File: rtl/run_counter.sv
// 8-bit saturating run counter. last flags that the next increment would
// land exactly on target, so the FSM can decide on the deciding sample.
module run_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] target,
  output logic       last
);

  logic [7:0] cnt;
  logic [8:0] cnt_p1;

  assign cnt_p1 = {1'b0, cnt} + 9'd1;
  assign last   = (cnt_p1 == {1'b0, target});

  // Clear has priority over increment; increment saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/detection_trip_filter.sv
// Debounced, latched protection trip driven by per-sample fault classes.
module detection_trip_filter
  import detection_pkg::*;
#(
  parameter int unsigned C           = 1,
  parameter int unsigned FAULT_CLASS = DEF_FAULT_CLASS,
  parameter int unsigned TRIP_CNT    = DEF_TRIP_CNT,
  parameter int unsigned CLEAR_CNT   = DEF_CLEAR_CNT,
  parameter int unsigned EW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [C-1:0]  cls_in,
  input  logic          cls_valid,
  input  logic          ack_clear,
  output logic          trip,
  output logic          trip_pulse,
  output logic          pending,
  output logic [EW-1:0] fault_events,
  output logic [1:0]    state_o
);

  trip_state_e state, next_state;
  logic        is_fault, is_healthy;
  logic        cnt_clr, cnt_inc, cnt_last;
  logic        trip_entry;
  logic [7:0]  cnt_target;

  assign is_fault   = cls_valid && (cls_in == FAULT_CLASS[C-1:0]);
  assign is_healthy = cls_valid && (cls_in != FAULT_CLASS[C-1:0]);
  assign cnt_target = (state == RECOVER) ? CLEAR_CNT[7:0] : TRIP_CNT[7:0];
  assign state_o    = state;

  run_counter u_run_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .target (cnt_target),
    .last   (cnt_last)
  );

  // Next-state and run-counter control. In NORMAL the counter is 0, so an
  // increment there yields cnt=1 on ARMING entry and last covers TRIP_CNT==1.
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    trip_entry = 1'b0;
    unique case (state)
      NORMAL, ARMING: begin
        if (is_fault) begin
          if (cnt_last) begin
            next_state = TRIPPED;
            cnt_clr    = 1'b1;
            trip_entry = 1'b1;
          end else begin
            next_state = ARMING;
            cnt_inc    = 1'b1;
          end
        end else if (is_healthy && (state == ARMING)) begin
          next_state = NORMAL;
          cnt_clr    = 1'b1;
        end
      end
      TRIPPED: begin
        if (ack_clear) begin
          next_state = RECOVER;
          cnt_clr    = 1'b1;
        end
      end
      RECOVER: begin
        if (is_healthy) begin
          if (cnt_last) begin
            next_state = NORMAL;
            cnt_clr    = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end else if (is_fault) begin
          next_state = TRIPPED;
          cnt_clr    = 1'b1;
        end
      end
      default: begin
        next_state = NORMAL;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  // State, registered outputs and saturating trip-event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= NORMAL;
      trip         <= 1'b0;
      trip_pulse   <= 1'b0;
      pending      <= 1'b0;
      fault_events <= '0;
    end else begin
      state      <= next_state;
      trip       <= (next_state == TRIPPED) || (next_state == RECOVER);
      pending    <= (next_state == ARMING);
      trip_pulse <= trip_entry;
      if (trip_entry && (fault_events != '1)) begin
        fault_events <= fault_events + EW'(1);
      end
    end
  end

endmodule

// File: tb/tb_detection_trip_filter.sv
// Directed bench for detection_trip_filter; second instance has EW=2.
module tb_detection_trip_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [0:0]  cls_in = 1'b1;
  logic        cls_valid = 1'b0;
  logic        ack_clear = 1'b0;

  logic        trip, trip_pulse, pending;
  logic [15:0] fault_events;
  logic [1:0]  state_o;
  logic        trip2, trip_pulse2, pending2;
  logic [1:0]  fault_events2;
  logic [1:0]  state_o2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  detection_trip_filter #(.C(1), .FAULT_CLASS(0), .TRIP_CNT(4), .CLEAR_CNT(8), .EW(16)) dut (
    .clk(clk), .rst(rst), .cls_in(cls_in), .cls_valid(cls_valid), .ack_clear(ack_clear),
    .trip(trip), .trip_pulse(trip_pulse), .pending(pending),
    .fault_events(fault_events), .state_o(state_o)
  );

  detection_trip_filter #(.C(1), .FAULT_CLASS(0), .TRIP_CNT(4), .CLEAR_CNT(8), .EW(2)) dut_ew2 (
    .clk(clk), .rst(rst), .cls_in(cls_in), .cls_valid(cls_valid), .ack_clear(ack_clear),
    .trip(trip2), .trip_pulse(trip_pulse2), .pending(pending2),
    .fault_events(fault_events2), .state_o(state_o2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // v: valid, c: class, a: ack. Returns #1 after the accepting edge.
  task automatic send(input logic v, input logic c, input logic a);
    cls_valid = v;
    cls_in    = c;
    ack_clear = a;
    @(posedge clk);
    #1;
    cls_valid = 1'b0;
    ack_clear = 1'b0;
  endtask

  task automatic expect_outs(input string tag, input logic tr, input logic tp, input logic pe,
                             input logic [1:0] st, input logic [15:0] ev);
    check_eq({tag, ".trip"}, 32'(trip), 32'(tr));
    check_eq({tag, ".pulse"}, 32'(trip_pulse), 32'(tp));
    check_eq({tag, ".pending"}, 32'(pending), 32'(pe));
    check_eq({tag, ".state"}, 32'(state_o), 32'(st));
    check_eq({tag, ".events"}, 32'(fault_events), 32'(ev));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    send(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    expect_outs(tag, 0, 0, 0, 2'd0, 16'd0);
    check_eq({tag, ".events2"}, 32'(fault_events2), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // 1: four consecutive faults trip on the 4th
    do_reset("t1.rst");
    send(1, 0, 0); expect_outs("t1.f1", 0, 0, 1, 2'd1, 16'd0);
    send(1, 0, 0); expect_outs("t1.f2", 0, 0, 1, 2'd1, 16'd0);
    send(1, 0, 0); expect_outs("t1.f3", 0, 0, 1, 2'd1, 16'd0);
    send(1, 0, 0); expect_outs("t1.f4", 1, 1, 0, 2'd2, 16'd1);
    send(0, 0, 0); expect_outs("t1.hold", 1, 0, 0, 2'd2, 16'd1);

    // 2: healthy sample breaks the run
    do_reset("t2.rst");
    for (int i = 0; i < 3; i++) send(1, 0, 0);
    expect_outs("t2.f3", 0, 0, 1, 2'd1, 16'd0);
    send(1, 1, 0); expect_outs("t2.h", 0, 0, 0, 2'd0, 16'd0);
    for (int i = 0; i < 3; i++) send(1, 0, 0);
    expect_outs("t2.g3", 0, 0, 1, 2'd1, 16'd0);
    send(1, 0, 0); expect_outs("t2.g4", 1, 1, 0, 2'd2, 16'd1);

    // 3: invalid gaps neither count nor break the run
    do_reset("t3.rst");
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0);
    send(0, 0, 0); send(0, 1, 0); send(1, 0, 0);
    expect_outs("t3.f3", 0, 0, 1, 2'd1, 16'd0);
    send(1, 0, 0); expect_outs("t3.f4", 1, 1, 0, 2'd2, 16'd1);

    // 4: trip holds without ack; ack-cycle sample not counted
    for (int i = 0; i < 20; i++) send(1, 1, 0);
    expect_outs("t4.noack", 1, 0, 0, 2'd2, 16'd1);
    send(1, 1, 1); expect_outs("t4.ack", 1, 0, 0, 2'd3, 16'd1);
    for (int i = 0; i < 7; i++) send(1, 1, 1);
    expect_outs("t4.h7", 1, 0, 0, 2'd3, 16'd1);
    send(1, 1, 0); expect_outs("t4.h8", 0, 0, 0, 2'd0, 16'd1);

    // 5: fault during RECOVER re-trips silently
    do_reset("t5.rst");
    for (int i = 0; i < 4; i++) send(1, 0, 0);
    send(0, 0, 1);
    for (int i = 0; i < 5; i++) send(1, 1, 0);
    expect_outs("t5.h5", 1, 0, 0, 2'd3, 16'd1);
    send(1, 0, 0); expect_outs("t5.retrip", 1, 0, 0, 2'd2, 16'd1);
    send(0, 0, 1);
    for (int i = 0; i < 7; i++) send(1, 1, 0);
    expect_outs("t5.h7", 1, 0, 0, 2'd3, 16'd1);
    send(1, 1, 0); expect_outs("t5.h8", 0, 0, 0, 2'd0, 16'd1);

    // 6: mid-operation reset in RECOVER and ARMING
    for (int i = 0; i < 4; i++) send(1, 0, 0);
    send(0, 0, 1); send(1, 1, 0); send(1, 1, 0);
    expect_outs("t6.rec", 1, 0, 0, 2'd3, 16'd2);
    rst = 1'b1; send(1, 0, 0); rst = 1'b0;
    expect_outs("t6.rstrec", 0, 0, 0, 2'd0, 16'd0);
    send(1, 0, 0); send(1, 0, 0);
    expect_outs("t6.arm", 0, 0, 1, 2'd1, 16'd0);
    rst = 1'b1; send(1, 0, 0); rst = 1'b0;
    expect_outs("t6.rstarm", 0, 0, 0, 2'd0, 16'd0);
    for (int i = 0; i < 3; i++) send(1, 0, 0);
    expect_outs("t6.restart", 0, 0, 1, 2'd1, 16'd0);

    // 6b: EW=2 counter saturates at 3
    do_reset("t6b.rst");
    for (int t = 1; t <= 4; t++) begin
      for (int i = 0; i < 4; i++) send(1, 0, 0);
      check_eq($sformatf("t6b.ev16_%0d", t), 32'(fault_events), 32'(t));
      check_eq($sformatf("t6b.ev2_%0d", t), 32'(fault_events2), (t > 3) ? 32'd3 : 32'(t));
      check_eq($sformatf("t6b.pulse2_%0d", t), 32'(trip_pulse2), 32'd1);
      send(0, 0, 1);
      for (int i = 0; i < 8; i++) send(1, 1, 0);
      check_eq($sformatf("t6b.clr2_%0d", t), 32'(trip2), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
